// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core and its run controller.
// Default widths, controller state encoding and the HLT opcode.
package mips_pkg;

    localparam int DW      = 32;
    localparam int IMEM_AW = 10;
    localparam int DMEM_AW = 10;
    localparam int RF_AW   = 5;

    localparam logic [5:0] OP_HLT = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR_RF,
        ST_INIT_DMEM,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } run_state_t;

endpackage

// File: rtl/mips_cycle_counter.sv
// RUN-cycle counter with synchronous clear, enable and a flag that marks
// the cycle whose increment lands exactly on the TIMEOUT budget.
module mips_cycle_counter #(
    parameter int CW      = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          term_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = en_i && (count_d == CW'(TIMEOUT));

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: clear RF, optional DMEM pattern fill, program load, run.
// DMEM fill is built only when MIPS_RUN_CTRL_DMEM_INIT_EN is defined.
module mips_run_ctrl #(
    parameter int DW      = mips_pkg::DW,
    parameter int IMEM_AW = mips_pkg::IMEM_AW,
    parameter int DMEM_AW = mips_pkg::DMEM_AW,
    parameter int RF_AW   = mips_pkg::RF_AW,
    parameter int CW      = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IMEM_AW:0]   prog_len,
    input  logic               prog_valid,
    input  logic [DW-1:0]      prog_data,
    output logic               prog_ready,
    output logic               rf_we,
    output logic [RF_AW-1:0]   rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DW-1:0]      imem_wdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DW-1:0]      dmem_wdata,
    output logic               cpu_rst,
    output logic               cpu_run,
    input  logic               cpu_halted,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CW-1:0]      cycle_count
);

    import mips_pkg::*;

    localparam int MAXAW = (IMEM_AW > DMEM_AW)
        ? ((IMEM_AW > RF_AW) ? IMEM_AW : RF_AW)
        : ((DMEM_AW > RF_AW) ? DMEM_AW : RF_AW);
    localparam int CNTW = MAXAW + 1;

    localparam logic [CNTW-1:0]  RF_LAST   = CNTW'((1 << RF_AW) - 1);
    localparam logic [CNTW-1:0]  DMEM_LAST = CNTW'((1 << DMEM_AW) - 1);
    localparam logic [IMEM_AW:0] IMEM_N    = {1'b1, {IMEM_AW{1'b0}}};

    run_state_t state_q, state_d;
    run_state_t after_rf, load_or_run;

    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [IMEM_AW:0]   len_q, len_d;
    logic               start_ok, accept, budget_end;

    logic               prog_ready_q, rf_we_q, imem_we_q;
    logic               cpu_rst_q, cpu_run_q, busy_q, done_q, timeout_q;
    logic               done_d, timeout_d;
    logic [RF_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [DW-1:0]      imem_wdata_q, imem_wdata_d;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign accept   = prog_valid && prog_ready_q;

    assign load_or_run = (len_q == '0) ? ST_RUN : ST_LOAD;
`ifdef MIPS_RUN_CTRL_DMEM_INIT_EN
    assign after_rf = ST_INIT_DMEM;
`else
    assign after_rf = load_or_run;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_CLR_RF;
                    len_d   = (prog_len > IMEM_N) ? IMEM_N : prog_len;
                end
            end
            ST_CLR_RF: begin
                if (cnt_q == RF_LAST) state_d = after_rf;
            end
`ifdef MIPS_RUN_CTRL_DMEM_INIT_EN
            ST_INIT_DMEM: begin
                if (cnt_q == DMEM_LAST) state_d = load_or_run;
            end
`endif
            ST_LOAD: begin
                if (accept && cnt_q == CNTW'(len_q - 1'b1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cpu_halted || budget_end) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The shared counter restarts at zero on every state entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_CLR_RF || state_q == ST_INIT_DMEM || accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        rf_waddr_d   = (state_d == ST_CLR_RF) ? cnt_d[RF_AW-1:0] : '0;
        imem_addr_d  = accept ? cnt_q[IMEM_AW-1:0] : '0;
        imem_wdata_d = accept ? prog_data : '0;
        done_d       = done_q;
        timeout_d    = timeout_q;
        if (start_ok) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == ST_RUN && state_d == ST_DONE) begin
            done_d    = 1'b1;
            timeout_d = !cpu_halted;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            prog_ready_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            prog_ready_q <= (state_d == ST_LOAD);
            rf_we_q      <= (state_d == ST_CLR_RF);
            rf_waddr_q   <= rf_waddr_d;
            imem_we_q    <= accept;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= (state_d != ST_RUN);
            cpu_run_q    <= (state_d == ST_RUN);
            busy_q       <= !(state_d == ST_IDLE || state_d == ST_DONE);
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef MIPS_RUN_CTRL_DMEM_INIT_EN
    logic               dmem_we_q;
    logic [DMEM_AW-1:0] dmem_addr_q;
    logic [DW-1:0]      dmem_wdata_q;
    logic [DMEM_AW-1:0] dmem_addr_d;

    assign dmem_addr_d = (state_d == ST_INIT_DMEM) ? cnt_d[DMEM_AW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            dmem_we_q    <= (state_d == ST_INIT_DMEM);
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= DW'(dmem_addr_d);
        end
    end

    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
`else
    assign dmem_we    = 1'b0;
    assign dmem_addr  = '0;
    assign dmem_wdata = '0;
`endif

    mips_cycle_counter #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_cycle_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start_ok),
        .en_i    (state_q == ST_RUN),
        .count_o (cycle_count),
        .term_o  (budget_end)
    );

    assign prog_ready = prog_ready_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = '0;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign cpu_run    = cpu_run_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a tiny fetch-only core model.
// Works with or without MIPS_RUN_CTRL_DMEM_INIT_EN defined.
module tb_mips_run_ctrl;

    import mips_pkg::*;

    localparam int IMEM_N = 1 << IMEM_AW;
`ifdef MIPS_RUN_CTRL_DMEM_INIT_EN
    localparam int INIT_CYC = 32 + 1024;
    localparam int EXP_DMEM = 1024;
`else
    localparam int INIT_CYC = 32;
    localparam int EXP_DMEM = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, prog_valid, prog_ready;
    logic [IMEM_AW:0]   prog_len;
    logic [DW-1:0]      prog_data, rf_wdata, imem_wdata, dmem_wdata;
    logic               rf_we, imem_we, dmem_we;
    logic [RF_AW-1:0]   rf_waddr;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DMEM_AW-1:0] dmem_addr;
    logic               cpu_rst, cpu_run, cpu_halted;
    logic               busy, done, timeout;
    logic [31:0]        cycle_count;

    mips_run_ctrl #(
        .DW(DW), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW),
        .RF_AW(RF_AW), .CW(32), .TIMEOUT(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
        .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .cpu_rst(cpu_rst), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    logic [31:0]        prog [4];
    logic [DW-1:0]      imem_m [IMEM_N];
    logic [7:0]         widx;
    logic               clr_mon, force_halt;
    int                 vmode;
    logic               tgl;

    assign prog_data = prog[widx[1:0]];

    // Fetch-only core: steps PC each run cycle, halts on an HLT opcode.
    logic [IMEM_AW-1:0] pc;
    logic               core_halt;
    assign cpu_halted = core_halt | force_halt;
    always @(posedge clk) begin
        if (cpu_rst) begin
            pc        <= '0;
            core_halt <= 1'b0;
        end else if (cpu_run && !core_halt) begin
            if (imem_m[pc][31:26] == OP_HLT) core_halt <= 1'b1;
            else pc <= pc + 1'b1;
        end
    end

    always @(negedge clk) begin
        case (vmode)
            1: prog_valid = 1'b1;
            2: begin
                if (prog_ready) begin
                    prog_valid = tgl;
                    tgl = !tgl;
                end else begin
                    prog_valid = 1'b0;
                    tgl = 1'b0;
                end
            end
            default: prog_valid = 1'b0;
        endcase
    end

    int cyc = 0;
    int n_rf, n_dmem, n_imem, n_ready, rf_bad, dmem_bad, imem_bad, multi;
    int ready_rise, run_rise, start_cyc;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_we) imem_m[imem_addr] <= imem_wdata;
        if (clr_mon) begin
            n_rf <= 0; n_dmem <= 0; n_imem <= 0; n_ready <= 0;
            rf_bad <= 0; dmem_bad <= 0; imem_bad <= 0; multi <= 0;
            ready_rise <= -1; run_rise <= -1; start_cyc <= -1;
            widx <= '0;
        end else begin
            if (rf_we) begin
                n_rf <= n_rf + 1;
                if (rf_waddr != RF_AW'(n_rf) || rf_wdata !== '0)
                    rf_bad <= rf_bad + 1;
            end
            if (dmem_we) begin
                n_dmem <= n_dmem + 1;
                if (dmem_addr != DMEM_AW'(n_dmem) || dmem_wdata !== DW'(dmem_addr))
                    dmem_bad <= dmem_bad + 1;
            end
            if (imem_we) begin
                n_imem <= n_imem + 1;
                if (imem_addr >= 4 || imem_wdata !== prog[imem_addr[1:0]])
                    imem_bad <= imem_bad + 1;
            end
            if (int'(rf_we) + int'(dmem_we) + int'(imem_we) > 1) multi <= multi + 1;
            if (prog_ready) begin
                n_ready <= n_ready + 1;
                if (ready_rise < 0) ready_rise <= cyc - 1;
            end
            if (cpu_run && run_rise < 0) run_rise <= cyc - 1;
            if (start && start_cyc < 0) start_cyc <= cyc;
            if (prog_valid && prog_ready) widx <= widx + 1'b1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int len, input int mode);
        @(negedge clk);
        clr_mon = 1'b1;
        vmode = mode;
        @(negedge clk);
        clr_mon = 1'b0;
        start = 1'b1;
        prog_len = (IMEM_AW+1)'(len);
        @(negedge clk);
        start = 1'b0;
        check("after_start", {busy, rf_we, done, timeout}, 4'b1100);
        check("after_start_addr", rf_waddr, 0);
        check("after_start_count", cycle_count, 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic wait_count(input int target);
        int n = 0;
        while (cycle_count != target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("count_reached", cycle_count, target);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; prog_len = '0;
        vmode = 0; tgl = 1'b0; force_halt = 1'b0; clr_mon = 1'b1;
        prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0007;
        prog[2] = 32'h0022_1820; prog[3] = {OP_HLT, 26'h0};
        repeat (3) @(negedge clk);
        check("reset_flags",
              {busy, done, timeout, cpu_rst, cpu_run, rf_we, dmem_we, imem_we, prog_ready},
              9'b000100000);
        check("reset_addrs", {rf_waddr, imem_addr, dmem_addr}, 0);
        check("reset_count", cycle_count, 0);
        rst_n = 1'b1;

        // Program ending in HLT at word 3, valid always high.
        launch(4, 1);
        wait_done(3000);
        @(negedge clk);
        check("t1_rf_writes", n_rf, 32);
        check("t1_rf_bad", rf_bad, 0);
        check("t1_dmem_writes", n_dmem, EXP_DMEM);
        check("t1_dmem_bad", dmem_bad, 0);
        check("t1_imem_writes", n_imem, 4);
        check("t1_imem_bad", imem_bad, 0);
        check("t1_ready_cycles", n_ready, 4);
        check("t1_load_start", ready_rise - start_cyc, INIT_CYC);
        check("t1_run_start", run_rise - start_cyc, INIT_CYC + 4);
        check("t1_timeout", timeout, 0);
        check("t1_cycles", cycle_count, 5);
        check("t1_multi_we", multi, 0);
        check("t1_imem3", imem_m[3], 32'hFC00_0000);
        check("t1_idle_outs", {busy, cpu_run, cpu_rst, done}, 4'b0011);

        // Same program, valid toggling.
        launch(4, 2);
        wait_done(3000);
        check("t2_ready_cycles", n_ready, 8);
        check("t2_run_start", run_rise - start_cyc, INIT_CYC + 8);
        check("t2_imem_writes", n_imem, 4);
        check("t2_imem_bad", imem_bad, 0);
        check("t2_imem0", imem_m[0], 32'h2001_0005);
        check("t2_cycles", cycle_count, 5);
        check("t2_timeout", timeout, 0);

        // No HLT: budget expires; start in RUN is ignored.
        prog[3] = 32'h0000_0020;
        launch(4, 1);
        wait_count(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_start_ignored", {busy, cpu_run, rf_we}, 3'b110);
        check("t3_count_kept", cycle_count, 101);
        wait_done(3000);
        check("t3_timeout", timeout, 1);
        check("t3_cycles", cycle_count, 1000);

        // Halt on the final budget cycle wins.
        launch(4, 1);
        wait_count(999);
        force_halt = 1'b1;
        @(negedge clk);
        force_halt = 1'b0;
        check("t4_done", done, 1);
        check("t4_timeout", timeout, 0);
        check("t4_cycles", cycle_count, 1000);

        // Reset in the middle of initialisation.
        launch(4, 1);
        begin
            int n = 0;
`ifdef MIPS_RUN_CTRL_DMEM_INIT_EN
            while (!(dmem_we && dmem_addr == 500) && n < 3000) begin
`else
            while (!(rf_we && rf_waddr == 10) && n < 3000) begin
`endif
                @(negedge clk);
                n++;
            end
            check("t5_reached", n < 3000, 1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_after_reset", {busy, dmem_we, rf_we, cpu_rst, done, cpu_run}, 6'b000100);
        check("t5_addr_cleared", {rf_waddr, dmem_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty program skips LOAD.
        launch(0, 1);
        wait_done(3000);
        check("t6_no_ready", n_ready, 0);
        check("t6_no_imem", n_imem, 0);
        check("t6_run_start", run_rise - start_cyc, INIT_CYC);
        check("t6_dmem_writes", n_dmem, EXP_DMEM);
        check("t6_timeout", timeout, 1);
        check("t6_cycles", cycle_count, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
